regfile_read_arbiter: RTL and testbench

Shares one 32-entry register-file read port (a 32:1 word mux indexed by a 5-bit select) among NREQ requesters in the processor. Each cycle it picks at most one pending read request round-robin and drives the mux select with that request's register address. It captures the mux output into a response register and returns the data tagged with the requester index over a valid/ready handshake.

---
 rtl/regfile_read_arbiter_if.sv | 32 +++
 rtl/regfile_read_arbiter.sv | 82 ++++++++
 tb/tb_regfile_read_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Bus between the shared register-file read port arbiter and its environment.
// Groups the requester side (valid/addr/ready), the shared read mux
// (mux_sel/mux_data) and the tagged response handshake. clock/reset_n stay
// plain ports on the arbiter.
//   slave  : arbiter side (drives req_ready, mux_sel, rsp_*)
//   master : environment side (requesters, read mux, response consumer)
interface regfile_read_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][4:0]  req_addr;   // entry i occupies bits [5i+4:5i]
  logic [NREQ-1:0]       req_ready;
  logic [4:0]            mux_sel;
  logic [WIDTH-1:0]      mux_data;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [4:0]            rsp_addr;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ready;

  modport slave (
    input  req_valid, req_addr, mux_data, rsp_ready,
    output req_ready, mux_sel, rsp_valid, rsp_id, rsp_addr, rsp_data
  );

  modport master (
    output req_valid, req_addr, mux_data, rsp_ready,
    input  req_ready, mux_sel, rsp_valid, rsp_id, rsp_addr, rsp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32-entry register-file read port among
// NREQ requesters. Each cycle at most one pending request is granted, its
// address drives the shared mux select, and the mux output is captured into
// a one-entry response register returned with the requester tag.
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - regfile_read_arbiter_if.slave: req_valid/req_addr/req_ready,
//              mux_sel/mux_data, rsp_valid/rsp_id/rsp_addr/rsp_data/rsp_ready
module regfile_read_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int ZERO_R0 = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regfile_read_arbiter_if.slave   bus
);

  logic [IDW-1:0]   rr_ptr;
  logic [4:0]       sel_q;      // last granted address, held when idle
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [4:0]       rsp_addr_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             can_issue;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;
  logic [4:0]       gnt_addr;

  // Response slot is free if empty or being drained at this edge, so a
  // drain and a new load can share the same cycle.
  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  // Scan from rr_ptr upward modulo NREQ. Walking the offsets from high to low
  // lets the lowest offset (closest to rr_ptr) overwrite earlier hits.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (can_issue && reset_n && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign gnt_addr      = bus.req_addr[gnt_id];
  assign bus.req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
  assign bus.mux_sel   = gnt_vld ? gnt_addr : sel_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else if (gnt_vld) begin
      rr_ptr      <= IDW'((int'(gnt_id) + 1) % NREQ);
      sel_q       <= gnt_addr;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_addr_q  <= gnt_addr;
      rsp_data_q  <= (ZERO_R0 != 0 && gnt_addr == 5'd0) ? '0 : bus.mux_data;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter. A reference model of the
// round-robin pointer predicts each grant; granted reads push the expected
// response into a scoreboard queue that is compared against rsp_* while the
// response is held and popped when it is drained. A second instance with
// ZERO_R0=0 sees the same stimulus to cover the non-zeroing read of r0.
module tb_regfile_read_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;     // ZERO_R0=1 instance
    logic [WIDTH-1:0] data_nz;  // ZERO_R0=0 instance
  } exp_t;

  logic clock;
  logic reset_n;
  logic [WIDTH-1:0] regs [32];

  regfile_read_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
  regfile_read_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus2 ();

  regfile_read_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ZERO_R0(1), .IDW(IDW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave));
  regfile_read_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ZERO_R0(0), .IDW(IDW)) dut_nz (
    .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

  // Shared read mux models, one per instance.
  assign bus.mux_data   = regs[bus.mux_sel];
  assign bus2.mux_data  = regs[bus2.mux_sel];
  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_addr  = bus.req_addr;
  assign bus2.rsp_ready = bus.rsp_ready;

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   m_ptr;
  logic [4:0] m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mux_sel",   32'(bus.mux_sel),   32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_rsp_addr",  32'(bus.rsp_addr),  32'h0);
    chk("rst_rsp_data",  bus.rsp_data,       32'h0);
  endtask

  // Called at a falling edge with inputs already driven; checks the cycle,
  // advances the model across the rising edge, returns at the next fall.
  task automatic cycle();
    int   g;
    bit   can;
    logic [NREQ-1:0] exp_rdy;
    logic [4:0] exp_sel;
    exp_t e;
    #1;
    can = (q.size() == 0) || bus.rsp_ready;
    g = -1;
    if (can)
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    exp_sel = (g >= 0) ? bus.req_addr[g] : m_sel;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("mux_sel",   32'(bus.mux_sel),   32'(exp_sel));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rsp_id",      32'(bus.rsp_id),   32'(q[0].id));
      chk("rsp_addr",    32'(bus.rsp_addr), 32'(q[0].addr));
      chk("rsp_data",    bus.rsp_data,      q[0].data);
      chk("rsp_data_nz", bus2.rsp_data,     q[0].data_nz);
    end
    @(posedge clock);
    if (q.size() != 0 && bus.rsp_ready) void'(q.pop_front());
    if (g >= 0) begin
      e.id      = IDW'(g);
      e.addr    = exp_sel;
      e.data_nz = regs[exp_sel];
      e.data    = (exp_sel == 5'd0) ? '0 : regs[exp_sel];
      q.push_back(e);
      m_ptr = (g + 1) % NREQ;
      m_sel = exp_sel;
    end
    @(negedge clock);
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_sel = '0;
  endtask

  initial begin
    clock         = 1'b0;
    reset_n       = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0011_0101;
    regs[0] = 32'hFFFF_FFFF;
    regs[5] = 32'hDEAD_BEEF;
    model_reset();

    // Power-on reset.
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single read of r5 by requester 0.
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 5'd5;
    bus.rsp_ready = 1'b1;
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();

    // All requesters pending, consumer always ready: one grant per cycle.
    bus.req_valid = 4'b1111;
    bus.req_addr[0] = 5'd1;
    bus.req_addr[1] = 5'd2;
    bus.req_addr[2] = 5'd3;
    bus.req_addr[3] = 5'd4;
    repeat (6) cycle();

    // Backpressure with a held response, then release with same-cycle grant.
    bus.rsp_ready = 1'b0;
    repeat (3) cycle();
    bus.rsp_ready = 1'b1;
    cycle();
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();

    // Read of r0: zeroed on one instance, raw on the other.
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 5'd0;
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();

    // Pointer wrap: steer rr_ptr to 3, then requesters 1 and 3.
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = 5'd7;
    cycle();
    bus.req_valid = 4'b1010;
    bus.req_addr[1] = 5'd9;
    bus.req_addr[3] = 5'd11;
    cycle();
    bus.req_valid = 4'b0010;
    cycle();
    bus.req_valid = 4'b1111;
    cycle();   // pointer now at 2: requester 2 wins

    // Mid-stream asynchronous reset with a response held.
    #3 reset_n = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    bus.req_valid = 4'b0101;
    cycle();   // requester 0 granted first after release
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
